// File: rtl/lsu_byte_seq_pkg.sv
// lsu_byte_seq_pkg: shared constants for the byte-sequencing load/store unit.
// Holds the CPU operation encoding, the data-memory command bit positions
// (shared with the data-memory block) and the sequencer FSM state type.
package lsu_byte_seq_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CTRL_W = 5;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned CNT_W  = 3;

  // CPU request operations
  localparam logic [OP_W-1:0] OP_LW  = 3'd0;
  localparam logic [OP_W-1:0] OP_LB  = 3'd1;
  localparam logic [OP_W-1:0] OP_LBU = 3'd2;
  localparam logic [OP_W-1:0] OP_LH  = 3'd3;
  localparam logic [OP_W-1:0] OP_LHU = 3'd4;
  localparam logic [OP_W-1:0] OP_SW  = 3'd5;
  localparam logic [OP_W-1:0] OP_SB  = 3'd6;
  localparam logic [OP_W-1:0] OP_SH  = 3'd7;

  // One-hot data-memory command bit positions
  localparam int unsigned CTRL_SW  = 4;
  localparam int unsigned CTRL_LW  = 3;
  localparam int unsigned CTRL_LB  = 2;
  localparam int unsigned CTRL_LBU = 1;
  localparam int unsigned CTRL_SB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/lsu_byte_seq_beat_plan.sv
// lsu_beat_plan: maps an operation and the low address bits to a beat count
// and the memory command issued on every beat of that access.
// Ports:
//   i_op        operation code
//   i_addr_lo   byte address bits [1:0]
//   o_beats_c   number of beats (1, 2 or 4), combinational
//   o_cmd_c     one-hot memory command used for each beat, combinational
module lsu_beat_plan
  import lsu_byte_seq_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [1:0]        i_addr_lo,
  output logic [CNT_W-1:0]  o_beats_c,
  output logic [CTRL_W-1:0] o_cmd_c
);

  logic w_aligned;

  assign w_aligned = (i_addr_lo == 2'b00);

  // Word ops fall back to byte beats when misaligned; halfwords are always split.
  always_comb begin
    o_beats_c = 3'd1;
    o_cmd_c   = '0;
    case (i_op)
      OP_LW: begin
        if (w_aligned) begin
          o_cmd_c[CTRL_LW] = 1'b1;
        end else begin
          o_beats_c         = 3'd4;
          o_cmd_c[CTRL_LBU] = 1'b1;
        end
      end
      OP_LB:  o_cmd_c[CTRL_LB]  = 1'b1;
      OP_LBU: o_cmd_c[CTRL_LBU] = 1'b1;
      OP_LH, OP_LHU: begin
        o_beats_c         = 3'd2;
        o_cmd_c[CTRL_LBU] = 1'b1;
      end
      OP_SW: begin
        if (w_aligned) begin
          o_cmd_c[CTRL_SW] = 1'b1;
        end else begin
          o_beats_c        = 3'd4;
          o_cmd_c[CTRL_SB] = 1'b1;
        end
      end
      OP_SB: o_cmd_c[CTRL_SB] = 1'b1;
      OP_SH: begin
        o_beats_c        = 3'd2;
        o_cmd_c[CTRL_SB] = 1'b1;
      end
      default: begin
        o_beats_c = 3'd1;
        o_cmd_c   = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: accepts one CPU load/store at a time and sequences it onto a
// byte/word data memory, splitting misaligned words and all halfwords into
// little-endian byte beats. Memory command/address/data are registered.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata  operation, byte address, store data
//   resp_valid/resp_ready      response handshake, held in DONE
//   resp_rdata                 load result (0 for stores)
//   mem_ctrl/mem_addr/mem_wdata one-hot command, address, write data
//   mem_rdata                  asynchronous read data for the current beat
module lsu_byte_seq
  import lsu_byte_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              r_state;
  logic [OP_W-1:0]     r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BEAT_W-1:0]   r_beat;
  logic [DATA_W-1:0]   r_result;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [CTRL_W-1:0]   r_mem_ctrl;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_idle;
  logic [OP_W-1:0]     w_plan_op;
  logic [ADDR_W-1:0]   w_plan_addr;
  logic [DATA_W-1:0]   w_plan_wdata;
  logic [CNT_W-1:0]    w_beats;
  logic [CTRL_W-1:0]   w_cmd;
  logic [BEAT_W-1:0]   w_nxt_idx;
  logic [ADDR_W-1:0]   w_nxt_addr;
  logic [DATA_W-1:0]   w_nxt_wdata;
  logic [DATA_W-1:0]   w_res;
  logic [DATA_W-1:0]   w_fmt;
  logic                w_last;

  // In IDLE the plan looks at the incoming request so beat 0 issues right
  // after the accept edge; afterwards it follows the latched request.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_plan_op    = w_idle ? req_op    : r_op;
  assign w_plan_addr  = w_idle ? req_addr  : r_addr;
  assign w_plan_wdata = w_idle ? req_wdata : r_wdata;

  lsu_beat_plan u_plan (
    .i_op      (w_plan_op),
    .i_addr_lo (w_plan_addr[1:0]),
    .o_beats_c (w_beats),
    .o_cmd_c   (w_cmd)
  );

  // Next beat to present: address wraps within the 7-bit space.
  assign w_nxt_idx  = w_idle ? '0 : r_beat + BEAT_W'(1);
  assign w_nxt_addr = w_plan_addr + ADDR_W'(w_nxt_idx);
  assign w_last     = ((CNT_W'(r_beat) + CNT_W'(1)) == w_beats);

  // Word stores send the whole word; byte stores send value byte k on [7:0].
  always_comb begin
    w_nxt_wdata = '0;
    if (w_cmd[CTRL_SW]) begin
      w_nxt_wdata = w_plan_wdata;
    end else if (w_cmd[CTRL_SB]) begin
      w_nxt_wdata = {24'd0, w_plan_wdata[{w_nxt_idx, 3'b000} +: 8]};
    end
  end

  // Result after capturing the beat currently on the memory bus.
  always_comb begin
    w_res = r_result;
    if (!is_store(r_op)) begin
      if (w_beats == CNT_W'(1)) begin
        w_res = mem_rdata;
      end else begin
        w_res[{r_beat, 3'b000} +: 8] = mem_rdata[7:0];
      end
    end
  end

  // Final response formatting; single-beat byte loads arrive pre-extended.
  always_comb begin
    case (r_op)
      OP_LH:               w_fmt = {{16{w_res[15]}}, w_res[15:0]};
      OP_LHU:              w_fmt = {16'd0, w_res[15:0]};
      OP_SW, OP_SB, OP_SH: w_fmt = '0;
      default:             w_fmt = w_res;
    endcase
  end

  // Sequencer FSM with registered handshake and memory outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_beat       <= '0;
      r_result     <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_ctrl   <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_state     <= ST_ACCESS;
            r_op        <= req_op;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_beat      <= '0;
            r_result    <= '0;
            r_req_ready <= 1'b0;
            r_mem_ctrl  <= w_cmd;
            r_mem_addr  <= w_nxt_addr;
            r_mem_wdata <= w_nxt_wdata;
          end
        end
        ST_ACCESS: begin
          r_result <= w_res;
          if (w_last) begin
            r_state      <= ST_DONE;
            r_mem_ctrl   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_fmt;
          end else begin
            r_beat      <= w_nxt_idx;
            r_mem_ctrl  <= w_cmd;
            r_mem_addr  <= w_nxt_addr;
            r_mem_wdata <= w_nxt_wdata;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_mem_ctrl  <= '0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign mem_ctrl   = r_mem_ctrl;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed scoreboard bench for lsu_byte_seq with a byte
// array data-memory model.
module tb_lsu_byte_seq;

  localparam logic [4:0] C_SW  = 5'b10000;
  localparam logic [4:0] C_LW  = 5'b01000;
  localparam logic [4:0] C_LB  = 5'b00100;
  localparam logic [4:0] C_LBU = 5'b00010;
  localparam logic [4:0] C_SB  = 5'b00001;

  localparam logic [2:0] T_LW = 3'd0, T_LB = 3'd1, T_LBU = 3'd2, T_LH = 3'd3,
                         T_LHU = 3'd4, T_SW = 3'd5, T_SB = 3'd6, T_SH = 3'd7;

  typedef struct {
    logic [4:0]  ctrl;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mask;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [6:0]  req_addr = 7'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [4:0]  mem_ctrl;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [128] = '{default: 8'h00};

  beat_t       exp_beats[$];
  logic [31:0] exp_resp[$];
  int          exp_lat[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_byte_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_ctrl   (mem_ctrl),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: asynchronous read, write on the clock edge.
  always_comb begin
    mem_rdata = 32'd0;
    if (mem_ctrl[3])
      mem_rdata = {mem[7'(mem_addr + 7'd3)], mem[7'(mem_addr + 7'd2)],
                   mem[7'(mem_addr + 7'd1)], mem[mem_addr]};
    else if (mem_ctrl[2])
      mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
    else if (mem_ctrl[1])
      mem_rdata = {24'd0, mem[mem_addr]};
  end

  always @(posedge clk) begin
    if (mem_ctrl[4]) begin
      for (int i = 0; i < 4; i++)
        mem[7'(mem_addr + 7'(i))] = mem_wdata[8*i +: 8];
    end
    if (mem_ctrl[0])
      mem[mem_addr] = mem_wdata[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Beat monitor: every issued memory command must match the next expected beat.
  always @(negedge clk) begin
    if (mem_ctrl !== 5'd0) begin
      chk("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
      if (exp_beats.size() != 0) begin
        beat_t b;
        b = exp_beats.pop_front();
        chk("beat_ctrl", 32'(mem_ctrl), 32'(b.ctrl));
        chk("beat_addr", 32'(mem_addr), 32'(b.addr));
        chk("beat_wdata", mem_wdata & b.mask, b.wdata & b.mask);
      end
    end
  end

  task automatic push_beat(input logic [4:0] c, input logic [6:0] a,
                           input logic [31:0] wd, input logic [31:0] m);
    beat_t b;
    b.ctrl = c; b.addr = a; b.wdata = wd; b.mask = m;
    exp_beats.push_back(b);
  endtask

  // Expected beat sequence for one request; returns the beat count.
  task automatic plan_beats(input logic [2:0] op, input logic [6:0] addr,
                            input logic [31:0] wd, output int nb);
    int n0;
    bit aligned;
    n0 = exp_beats.size();
    aligned = (addr[1:0] == 2'b00);
    case (op)
      T_LW: if (aligned) push_beat(C_LW, addr, 0, 0);
            else for (int k = 0; k < 4; k++) push_beat(C_LBU, 7'(addr + 7'(k)), 0, 0);
      T_LB:  push_beat(C_LB, addr, 0, 0);
      T_LBU: push_beat(C_LBU, addr, 0, 0);
      T_LH, T_LHU: for (int k = 0; k < 2; k++) push_beat(C_LBU, 7'(addr + 7'(k)), 0, 0);
      T_SW: if (aligned) push_beat(C_SW, addr, wd, 32'hFFFF_FFFF);
            else for (int k = 0; k < 4; k++)
              push_beat(C_SB, 7'(addr + 7'(k)), wd >> (8*k), 32'hFF);
      T_SB:  push_beat(C_SB, addr, wd, 32'hFF);
      default: for (int k = 0; k < 2; k++)
                 push_beat(C_SB, 7'(addr + 7'(k)), wd >> (8*k), 32'hFF);
    endcase
    nb = exp_beats.size() - n0;
  endtask

  // One full transaction; called #1 after a clock edge with the DUT idle.
  task automatic issue(input string tag, input logic [2:0] op, input logic [6:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input int hold, input bit noise);
    int nb, lat;
    logic [31:0] exp_r;
    plan_beats(op, addr, wd, nb);
    exp_resp.push_back(exp_rd);
    exp_lat.push_back(nb);
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    if (noise) begin
      req_op = T_SB; req_addr = 7'h33; req_wdata = 32'hDEAD_BEEF;
    end else begin
      req_valid = 1'b0;
    end
    if (hold > 0) resp_ready = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    chk({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
    exp_r = exp_resp.pop_front();
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat.pop_front()));
    chk({tag, ":rdata"}, resp_rdata, exp_r);
    chk({tag, ":beats_left"}, 32'(exp_beats.size()), 32'd0);
    exp_beats.delete();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, resp_rdata, exp_r);
      chk({tag, ":hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ":hold_mem_ctrl"}, 32'(mem_ctrl), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":idle_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst:req_ready", 32'(req_ready), 32'd1);
    chk("rst:resp_valid", 32'(resp_valid), 32'd0);
    chk("rst:resp_rdata", resp_rdata, 32'd0);
    chk("rst:mem_ctrl", 32'(mem_ctrl), 32'd0);
    chk("rst:mem_addr", 32'(mem_addr), 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);

    issue("sw_aligned", T_SW, 7'h08, 32'h1122_3344, 32'h0, 0, 0);
    issue("lw_aligned", T_LW, 7'h08, 32'h0, 32'h1122_3344, 0, 0);
    issue("sw_unalign", T_SW, 7'h05, 32'hAABB_CCDD, 32'h0, 0, 0);
    issue("lw_unalign", T_LW, 7'h05, 32'h0, 32'hAABB_CCDD, 0, 0);
    issue("sh_wrap",    T_SH, 7'h7F, 32'h0000_8081, 32'h0, 0, 0);
    issue("lh_wrap",    T_LH, 7'h7F, 32'h0, 32'hFFFF_8081, 0, 0);
    issue("lhu_wrap",   T_LHU, 7'h7F, 32'h0, 32'h0000_8081, 0, 1);
    issue("sb_f0",      T_SB, 7'h10, 32'h0000_00F0, 32'h0, 0, 0);
    issue("lb_f0",      T_LB, 7'h10, 32'h0, 32'hFFFF_FFF0, 0, 0);
    issue("lbu_f0",     T_LBU, 7'h10, 32'h0, 32'h0000_00F0, 0, 0);
    issue("lw_backpr",  T_LW, 7'h08, 32'h0, 32'h1122_33AA, 3, 1);
    issue("sw_prefill", T_SW, 7'h20, 32'h5555_5555, 32'h0, 0, 0);

    // Reset during an unaligned store after its first byte beat.
    begin
      int nb;
      plan_beats(T_SW, 7'h21, 32'h0403_0201, nb);
      while (exp_beats.size() > 1) void'(exp_beats.pop_back());
      chk("rstmid:req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = T_SW; req_addr = 7'h21; req_wdata = 32'h0403_0201;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      #1;
      chk("rstmid:mem_ctrl_async", 32'(mem_ctrl), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("rstmid:beats_left", 32'(exp_beats.size()), 32'd0);
      chk("rstmid:req_ready", 32'(req_ready), 32'd1);
      chk("rstmid:resp_valid", 32'(resp_valid), 32'd0);
      chk("rstmid:resp_rdata", resp_rdata, 32'd0);
      chk("rstmid:mem_ctrl", 32'(mem_ctrl), 32'd0);
      chk("rstmid:mem_addr", 32'(mem_addr), 32'd0);
      chk("rstmid:mem_wdata", mem_wdata, 32'd0);
      chk("rstmid:byte21", 32'(mem[7'h21]), 32'h01);
      chk("rstmid:byte22", 32'(mem[7'h22]), 32'h55);
      chk("rstmid:byte23", 32'(mem[7'h23]), 32'h55);
      chk("rstmid:byte24", 32'(mem[7'h24]), 32'h00);
    end

    issue("lw_after_rst", T_LW, 7'h20, 32'h0, 32'h5555_0155, 0, 0);

    chk("end:beats_empty", 32'(exp_beats.size()), 32'd0);
    chk("end:resp_empty", 32'(exp_resp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_byte_seq.md
LSU_BYTE_SEQ -- requirements
Module: lsu_byte_seq

Interface
REQ-001 clk  input  1  clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  1  CPU presents a load/store request.
REQ-004 req_ready  output  1  block accepts a request; a request transfers when req_valid and req_ready are both high at the clock edge.
REQ-005 req_op  input  3  operation: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 SW, 6 SB, 7 SH.
REQ-006 req_addr  input  7  byte address.
REQ-007 req_wdata  input  32  store data; low byte or low halfword is used for SB or SH.
REQ-008 resp_valid  output  1  access complete; resp_rdata valid for loads.
REQ-009 resp_ready  input  1  CPU accepts the response.
REQ-010 resp_rdata  output  32  load result; 0 for stores.
REQ-011 mem_ctrl  output  5  one-hot data-memory command: bit4 sw, bit3 lw, bit2 lb, bit1 lbu, bit0 sb.
REQ-012 mem_addr  output  7  data-memory byte address.
REQ-013 mem_wdata  output  32  data-memory write data; byte ops use [7:0].
REQ-014 mem_rdata  input  32  data-memory asynchronous read data, valid in the same cycle as mem_ctrl and mem_addr.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 On accept, the block SHALL latch op, addr and wdata, set the beat index to 0, and enter ACCESS.
REQ-018 Beat count SHALL be set as follows:
- LW or SW with addr[1:0]==0: 1 beat using a word command (lw or sw).
- LB, LBU or SB: 1 beat using the native byte command.
- LH, LHU or SH: 2 byte beats.
- LW or SW with addr[1:0]!=0: 4 byte beats.
REQ-019 Multi-beat loads SHALL issue lbu per beat. Multi-beat stores SHALL issue sb per beat.
REQ-020 For beat k, mem_addr SHALL be (addr+k) mod 128, so address 127 wraps to 0.
REQ-021 Byte order SHALL be little-endian: beat k carries value byte k.
- Stores drive mem_wdata[7:0] = wdata[8k+7:8k].
- Loads capture mem_rdata[7:0] into result byte k at the clock edge.
REQ-022 ACCESS SHALL issue exactly one beat per cycle and enter DONE after the last beat.
REQ-023 mem_ctrl SHALL be 0 in IDLE and DONE. mem_ctrl SHALL have at most one bit set in ACCESS.
REQ-024 resp_rdata for loads SHALL be formed as follows:
- LW: full word.
- LB and LBU: the mem_rdata value as returned by the memory (already extended by the memory).
- LH: bits [31:16] are copies of bit 15.
- LHU: bits [31:16] are 0.
REQ-025 DONE SHALL hold resp_valid=1 and a stable resp_rdata until resp_ready=1. The block SHALL then return to IDLE on that edge.
REQ-026 Latency from accept edge to the first resp_valid cycle SHALL equal the beat count (1, 2 or 4 cycles) when resp_ready is held high.
REQ-027 req_valid in ACCESS or DONE SHALL be ignored; no request is queued.
REQ-028 The captured result register SHALL be cleared on accept.

Reset
REQ-029 Reset SHALL force state IDLE and clear the latched request, the beat index and the result register. It SHALL also drive resp_valid=0, resp_rdata=0, mem_ctrl=0, mem_addr=0 and mem_wdata=0.
REQ-030 Reset asserted mid-ACCESS SHALL suppress all remaining beats. Bytes already written remain in memory; no further write occurs.
REQ-031 The first accept after reset release SHALL occur no earlier than the first clock edge with reset low.

Structure
REQ-032 A shared package SHALL define:
- the req_op encoding constants;
- mem_ctrl bit positions (SW=4, LW=3, LB=2, LBU=1, SB=0);
- the FSM state type.
REQ-033 The data-memory command bit positions SHALL be shared with the data-memory block through that package.
REQ-034 One sub-module, lsu_beat_plan, SHALL map (op, addr[1:0]) to beat count and per-beat command. The FSM, address increment and byte assembly SHALL stay in lsu_byte_seq.

Verification
REQ-035 SW addr=0x08 wdata=0x11223344, then LW addr=0x08 -> one sw beat, then one lw beat; resp_rdata=0x11223344; each response arrives 1 cycle after accept.
REQ-036 SW addr=0x05 wdata=0xAABBCCDD -> four sb beats at 0x05..0x08 with bytes DD, CC, BB, AA; then LW addr=0x05 -> 0xAABBCCDD after 4 cycles.
REQ-037 SH addr=0x7F wdata=0x00008081 -> sb 0x81 at 0x7F, then sb 0x80 at 0x00; LH addr=0x7F -> 0xFFFF8081; LHU addr=0x7F -> 0x00008081.
REQ-038 With memory holding 0x000000F0 at 0x10: LB addr=0x10 -> 0xFFFFFFF0; LBU addr=0x10 -> 0x000000F0.
REQ-039 Backpressure: resp_ready held low for 3 cycles -> resp_valid and resp_rdata stay stable, req_ready=0, mem_ctrl=0; resp_ready high -> IDLE on the next cycle.
REQ-040 Reset after beat 1 of an unaligned SW to 0x21 -> only byte 0x21 is modified; outputs are 0 and req_ready=1 after release.
